// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule definitions: key width, round constants, FSM states
// and a helper for slicing 32-bit words out of a 128-bit key (word 0 is the MSW).
package aes_key_pkg;

  localparam int BLOCK_LENGTH = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] get_word(input logic [BLOCK_LENGTH-1:0] k, input logic [1:0] i);
    return k[(3 - i) * 32 +: 32];
  endfunction

endpackage

// File: rtl/inv_key_schedule_dec_if.sv
// Handshake bundle between the round-key sequencer (slave) and its user (master).
interface inv_key_schedule_dec_if;
  import aes_key_pkg::*;

  logic                    start;
  logic [BLOCK_LENGTH-1:0] key;
  logic                    key_ready;
  logic [BLOCK_LENGTH-1:0] round_key;
  logic                    round_key_valid;
  logic [3:0]              round_idx;
  logic                    busy;
  logic                    done;

  modport master (
    output start, key, key_ready,
    input  round_key, round_key_valid, round_idx, busy, done
  );

  modport slave (
    input  start, key, key_ready,
    output round_key, round_key_valid, round_idx, busy, done
  );

endinterface

// File: rtl/g_function.sv
// AES key-schedule g(): SubWord(RotWord(w)) xor {rc,24'h0}; purely combinational.
module g_function (
  input  logic [31:0] w,
  input  logic [7:0]  rc,
  output logic [31:0] g
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    g = {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]} ^ {rc, 24'h0};
  end

endmodule

// File: rtl/inv_key_schedule_dec.sv
// Reverse-order AES-128 round-key sequencer: expands K0 forward to K10 in one register,
// then emits K10..K0 over valid/ready, undoing one key step per accepted key.
module inv_key_schedule_dec
  import aes_key_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  inv_key_schedule_dec_if.slave kif
);

  state_t                  state_q, state_d;
  logic [BLOCK_LENGTH-1:0] key_q, key_d;
  logic [3:0]              rc_q, rc_d;
  logic [3:0]              idx_q, idx_d;
  logic                    done_q, done_d;

  logic                    accept;
  logic [31:0]             g_in, g_out;
  logic [7:0]              g_rc;
  logic [31:0]             w0, w1, w2, w3;
  logic [BLOCK_LENGTH-1:0] fwd_key, inv_key;

  assign w0 = get_word(key_q, 2'd0);
  assign w1 = get_word(key_q, 2'd1);
  assign w2 = get_word(key_q, 2'd2);
  assign w3 = get_word(key_q, 2'd3);

  assign accept = (state_q == EMIT) && kif.key_ready;

  // One shared g(): in EMIT the previous key's last word is recovered as w7^w6.
  assign g_in = (state_q == EMIT) ? (w3 ^ w2) : w3;
  assign g_rc = (state_q == EMIT) ? rcon(idx_q) : rcon(rc_q);

  g_function u_g (
    .w  (g_in),
    .rc (g_rc),
    .g  (g_out)
  );

  always_comb begin
    logic [31:0] n0, n1, n2, n3;
    n0 = w0 ^ g_out;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    fwd_key = {n0, n1, n2, n3};
    inv_key = {w0 ^ g_out, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (kif.start) state_d = EXPAND;
      EXPAND:  if (rc_q == 4'd10) state_d = EMIT;
      EMIT:    if (accept && (idx_q == 4'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= '0;
      rc_q   <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      key_q  <= key_d;
      rc_q   <= rc_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    key_d  = key_q;
    rc_d   = rc_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (kif.start) begin
          key_d = kif.key;
          rc_d  = 4'd1;
        end
      end
      EXPAND: begin
        key_d = fwd_key;
        rc_d  = rc_q + 4'd1;
        if (rc_q == 4'd10) idx_d = 4'd10;
      end
      EMIT: begin
        if (accept) begin
          if (idx_q == 4'd0) begin
            done_d = 1'b1;
          end else begin
            key_d = inv_key;
            idx_d = idx_q - 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    kif.round_key       = key_q;
    kif.round_idx       = idx_q;
    kif.round_key_valid = (state_q == EMIT);
    kif.busy            = (state_q != IDLE);
    kif.done            = done_q;
  end

endmodule
